// File: rtl/lab2_proc_int_div_unit.sv
// Iterative 32-bit integer divider: one restoring shift-subtract step per cycle, fixed
// 32-cycle latency for DIV/DIVU/REM/REMU, val/rdy request and response interfaces.
module lab2_proc_int_div_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_val,
    output logic        req_rdy,
    input  logic [1:0]  req_fn,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic        resp_val,
    input  logic        resp_rdy,
    output logic [31:0] resp_msg
);

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StDone
    } state_e;

    state_e      state_q, state_d;

    logic        rem_sel_q;
    logic        q_neg_q;
    logic        r_neg_q;
    logic [31:0] divisor_q;
    logic [63:0] rq_q, rq_d;
    logic [5:0]  cnt_q;
    logic [31:0] result_q, result_d;

    logic        req_xfer;
    logic        resp_xfer;
    logic        last_step;

    logic        signed_op;
    logic        a_neg;
    logic        b_neg;
    logic        b_zero;
    logic [31:0] a_mag;
    logic [31:0] b_mag;

    logic [32:0] partial;
    logic [32:0] diff;
    logic [31:0] quot;
    logic [31:0] rem;
    logic [31:0] quot_fix;
    logic [31:0] rem_fix;

    assign req_xfer  = req_val & req_rdy;
    assign resp_xfer = resp_val & resp_rdy;
    assign last_step = (state_q == StCalc) && (cnt_q == 6'd1);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (req_xfer)  state_d = StCalc;
            StCalc:  if (last_step) state_d = StDone;
            StDone:  if (resp_xfer) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM: outputs
    always_comb begin
        req_rdy  = (state_q == StIdle) && reset;
        resp_val = (state_q == StDone);
        resp_msg = resp_val ? result_q : 32'd0;
    end

    // ------------------------------------------------------------------
    // Operand decode at accept time
    // ------------------------------------------------------------------
    always_comb begin
        signed_op = ~req_fn[0];
        a_neg     = signed_op & req_a[31];
        b_neg     = signed_op & req_b[31];
        b_zero    = (req_b == 32'd0);
        a_mag     = a_neg ? (~req_a + 32'd1) : req_a;
        b_mag     = b_neg ? (~req_b + 32'd1) : req_b;
    end

    // ------------------------------------------------------------------
    // One restoring step; partial is 33 bits because an unsigned divisor
    // can exceed 2^31, so the shifted remainder may carry out of 32 bits.
    // ------------------------------------------------------------------
    always_comb begin
        partial = rq_q[63:31];
        diff    = partial - {1'b0, divisor_q};
        if (!diff[32]) begin
            rq_d = {diff[31:0], rq_q[30:0], 1'b1};
        end else begin
            rq_d = {rq_q[62:0], 1'b0};
        end
    end

    // Sign fix-up of the final step, folded in so DONE already holds the answer
    always_comb begin
        quot     = rq_d[31:0];
        rem      = rq_d[63:32];
        quot_fix = q_neg_q ? (~quot + 32'd1) : quot;
        rem_fix  = r_neg_q ? (~rem + 32'd1) : rem;
        result_d = rem_sel_q ? rem_fix : quot_fix;
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rem_sel_q <= 1'b0;
            q_neg_q   <= 1'b0;
            r_neg_q   <= 1'b0;
            divisor_q <= 32'd0;
            rq_q      <= 64'd0;
            cnt_q     <= 6'd0;
            result_q  <= 32'd0;
        end else if (req_xfer) begin
            rem_sel_q <= req_fn[1];
            // Divide-by-zero yields an all-ones quotient magnitude that must stay unsigned
            q_neg_q   <= (a_neg ^ b_neg) & ~b_zero;
            r_neg_q   <= a_neg;
            divisor_q <= b_mag;
            rq_q      <= {32'd0, a_mag};
            cnt_q     <= 6'd32;
        end else if (state_q == StCalc) begin
            rq_q  <= rq_d;
            cnt_q <= cnt_q - 6'd1;
            if (last_step) begin
                result_q <= result_d;
            end
        end
    end

endmodule

// File: tb/tb_lab2_proc_int_div_unit.sv
// Scoreboard bench for lab2_proc_int_div_unit: directed and random operations checked
// against an arithmetic reference model, with latency, backpressure and reset checks.
module tb_lab2_proc_int_div_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_val = 1'b0;
    logic        req_rdy;
    logic [1:0]  req_fn = 2'd0;
    logic [31:0] req_a = 32'd0;
    logic [31:0] req_b = 32'd0;
    logic        resp_val;
    logic        resp_rdy = 1'b0;
    logic [31:0] resp_msg;

    always #5 clk = ~clk;

    lab2_proc_int_div_unit dut (
        .clk      (clk),
        .reset    (reset),
        .req_val  (req_val),
        .req_rdy  (req_rdy),
        .req_fn   (req_fn),
        .req_a    (req_a),
        .req_b    (req_b),
        .resp_val (resp_val),
        .resp_rdy (resp_rdy),
        .resp_msg (resp_msg)
    );

    typedef struct {
        logic [31:0] exp;
        int          acc_edge;
    } exp_t;

    exp_t        sb_q[$];
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    bit          mon_en = 1'b0;
    bit          rand_rdy = 1'b0;
    bit          b2b = 1'b0;
    bit          prev_val = 1'b0;
    logic [31:0] prev_msg = 32'd0;
    int          last_resp_edge = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference behaviour from the arithmetic definition of each operation
    function automatic logic [31:0] model(input logic [1:0] fn, input logic [31:0] a,
                                          input logic [31:0] b);
        int sa;
        int sb;
        sa = $signed(a);
        sb = $signed(b);
        case (fn)
            2'd0: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return sa / sb;
            end
            2'd1: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            2'd2: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return sa % sb;
            end
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return $urandom_range(0, 15);
            default: return $urandom;
        endcase
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            resp_rdy = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: compares each new response against the scoreboard head
    always @(negedge clk) begin
        if (!reset || !mon_en) begin
            prev_val = 1'b0;
        end else begin
            if (!resp_val) begin
                check("msg_zero_when_invalid", resp_msg, 32'd0);
            end else begin
                check("req_rdy_low_in_done", {31'd0, req_rdy}, 32'd0);
                if (!prev_val) begin
                    if (sb_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_resp: got %h, expected no response", resp_msg);
                    end else begin
                        check("latency", 32'(cyc - sb_q[0].acc_edge), 32'd32);
                        check("result", resp_msg, sb_q[0].exp);
                    end
                end else begin
                    check("msg_stable", resp_msg, prev_msg);
                end
                if (resp_rdy) begin
                    if (sb_q.size() > 0) void'(sb_q.pop_front());
                    last_resp_edge = cyc + 1;
                end
            end
            prev_val = resp_val && !resp_rdy;
            prev_msg = resp_msg;
        end
    end

    // Call at a falling edge; returns 1 time unit after the accepting edge
    task automatic send(input logic [1:0] fn, input logic [31:0] a, input logic [31:0] b,
                        input bit hold_val);
        int   w;
        exp_t e;
        w       = 0;
        req_val = 1'b1;
        req_fn  = fn;
        req_a   = a;
        req_b   = b;
        while (!req_rdy && w < 400) begin
            @(negedge clk);
            w++;
        end
        if (!req_rdy) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: req_rdy 0, expected 1");
            req_val = 1'b0;
            return;
        end
        e.exp      = model(fn, a, b);
        e.acc_edge = cyc + 1;
        if (b2b && last_resp_edge >= 0) begin
            check("b2b_accept_gap", 32'(e.acc_edge - last_resp_edge), 32'd1);
        end
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        req_val = hold_val;
        // Inputs wander after accept; the result must not follow them
        req_fn  = 2'($urandom);
        req_a   = $urandom;
        req_b   = $urandom;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sb_q.size() != 0 && w < 1000) begin
            @(negedge clk);
            w++;
        end
        if (sb_q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: %0d responses outstanding, expected 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    logic [1:0]  d_fn[11] = '{2'd1, 2'd3, 2'd0, 2'd2, 2'd2, 2'd0, 2'd3, 2'd0, 2'd2, 2'd2, 2'd0};
    logic [31:0] d_a[11]  = '{32'd100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7, 32'd5,
                              32'd5, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFF9,
                              32'hFFFF_FFF9};
    logic [31:0] d_b[11]  = '{32'd7, 32'd7, 32'd2, 32'd2, 32'hFFFF_FFFE, 32'd0, 32'd0,
                              32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};

    initial begin
        int w;
        #1;
        check("rst_req_rdy", {31'd0, req_rdy}, 32'd0);
        check("rst_resp_val", {31'd0, resp_val}, 32'd0);
        check("rst_resp_msg", resp_msg, 32'd0);
        repeat (3) @(negedge clk);
        reset    = 1'b1;
        mon_en   = 1'b1;
        resp_rdy = 1'b1;
        #1;
        check("rdy_after_reset", {31'd0, req_rdy}, 32'd1);
        @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            send(d_fn[i], d_a[i], d_b[i], 1'b0);
            drain();
        end

        // Backpressure: response held for five cycles
        resp_rdy = 1'b0;
        send(2'd1, 32'd100, 32'd7, 1'b0);
        w = 0;
        while (!resp_val && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("bp_resp_val", {31'd0, resp_val}, 32'd1);
        repeat (5) begin
            @(negedge clk);
            check("bp_hold_val", {31'd0, resp_val}, 32'd1);
            check("bp_hold_msg", resp_msg, 32'h0000_000E);
        end
        @(posedge clk);
        #1;
        resp_rdy = 1'b1;
        @(posedge clk);
        #1;
        check("bp_idle_rdy", {31'd0, req_rdy}, 32'd1);
        check("bp_val_low", {31'd0, resp_val}, 32'd0);
        drain();

        // Back-to-back with req_val held high
        b2b            = 1'b1;
        last_resp_edge = -1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            send(2'($urandom), pick(), pick(), 1'b1);
        end
        req_val = 1'b0;
        drain();
        b2b = 1'b0;

        // Random operations with random response backpressure
        rand_rdy = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            send(2'($urandom), pick(), pick(), 1'b0);
        end
        drain();
        rand_rdy = 1'b0;
        @(posedge clk);
        #2;
        resp_rdy = 1'b1;

        // Reset abort during iteration 10 of DIVU 1000/3
        @(negedge clk);
        send(2'd1, 32'd1000, 32'd3, 1'b0);
        repeat (10) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("abort_req_rdy", {31'd0, req_rdy}, 32'd0);
        check("abort_resp_val", {31'd0, resp_val}, 32'd0);
        check("abort_resp_msg", resp_msg, 32'd0);
        sb_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_rdy_after", {31'd0, req_rdy}, 32'd1);
        @(negedge clk);
        send(2'd1, 32'd9, 32'd3, 1'b0);
        drain();

        repeat (40) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not complete, expected completion");
        $fatal(1, "timeout");
    end

endmodule
